// File: rtl/keyspace_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : keyspace_sequencer
// Description : Keyspace odometer and length sweep that dispatches one candidate
//               per cycle round-robin to NCORES hash cores. Optional candidate
//               counter is enabled by defining KS_PROGRESS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module keyspace_sequencer #(
    parameter int MAXLEN = 16,
    parameter int NCORES = 4,
    parameter int LW     = 5,
    parameter int CW     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_load,
    input  logic [7:0]          cfg_numchars,
    input  logic [LW-1:0]       cfg_min_len,
    input  logic [LW-1:0]       cfg_max_len,
    input  logic                start,
    input  logic                abort,
    input  logic [NCORES-1:0]   core_ready,
    output logic                out_valid,
    output logic [CW-1:0]       out_core,
    output logic [8*MAXLEN-1:0] out_idx,
    output logic [LW-1:0]       out_len,
    input  logic                match_valid,
    input  logic [CW-1:0]       match_core,
    output logic                busy,
    output logic                exhausted,
    output logic                found,
    output logic [CW-1:0]       found_core,
`ifdef KS_PROGRESS_EN
    output logic [47:0]         cand_count,
`endif
    output logic                cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [7:0]      r_numchars;
    logic [LW-1:0]   r_min_len;
    logic [LW-1:0]   r_max_len;
    logic            r_cfg_loaded;
    logic [7:0]      r_digit [MAXLEN];
    logic [LW-1:0]   r_len;
    logic [CW-1:0]   r_rr_ptr;

    logic [7:0]      w_digit_nxt [MAXLEN];
    logic            w_wrap_all;
    logic            w_any;
    logic [CW-1:0]   w_pick;
    logic [CW-1:0]   w_c;
    logic            w_cfg_illegal;
    logic            w_xfer;

    assign w_cfg_illegal = (cfg_numchars == 8'd0) || (cfg_numchars > 8'd127) ||
                           (cfg_min_len == '0) || (cfg_min_len > cfg_max_len) ||
                           (cfg_max_len > LW'(MAXLEN));

    // First ready core at or after the round-robin pointer.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_c    = '0;
        for (int k = 0; k < NCORES; k++) begin
            w_c = CW'((int'(r_rr_ptr) + k) % NCORES);
            if (!w_any && core_ready[w_c]) begin
                w_any  = 1'b1;
                w_pick = w_c;
            end
        end
    end

    // Ripple increment over the active digits; w_wrap_all is the carry out of digit len-1.
    always_comb begin
        w_wrap_all = 1'b1;
        for (int i = 0; i < MAXLEN; i++) begin
            w_digit_nxt[i] = r_digit[i];
            if (w_wrap_all && (LW'(i) < r_len)) begin
                if (r_digit[i] == r_numchars - 8'd1) begin
                    w_digit_nxt[i] = 8'd0;
                end else begin
                    w_digit_nxt[i] = r_digit[i] + 8'd1;
                    w_wrap_all     = 1'b0;
                end
            end
        end
    end

    assign busy      = (r_state == S_RUN);
    assign out_valid = busy && w_any;
    assign out_core  = w_pick;
    assign out_len   = r_len;
    assign w_xfer    = out_valid;

    generate
        for (genvar gi = 0; gi < MAXLEN; gi++) begin : g_idx
            assign out_idx[8*gi +: 8] = r_digit[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_numchars   <= '0;
            r_min_len    <= '0;
            r_max_len    <= '0;
            r_cfg_loaded <= 1'b0;
            r_digit      <= '{default: '0};
            r_len        <= '0;
            r_rr_ptr     <= '0;
            exhausted    <= 1'b0;
            found        <= 1'b0;
            found_core   <= '0;
            cfg_err      <= 1'b0;
        end else if (abort) begin
            r_state   <= S_IDLE;
            exhausted <= 1'b0;
            found     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_load) begin
                        r_numchars   <= cfg_numchars;
                        r_min_len    <= cfg_min_len;
                        r_max_len    <= cfg_max_len;
                        r_cfg_loaded <= 1'b1;
                        cfg_err      <= w_cfg_illegal;
                    end else if (start && r_cfg_loaded && !cfg_err) begin
                        r_digit   <= '{default: '0};
                        r_len     <= r_min_len;
                        r_rr_ptr  <= '0;
                        exhausted <= 1'b0;
                        found     <= 1'b0;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_xfer) begin
                        r_rr_ptr <= (w_pick == CW'(NCORES - 1)) ? '0 : w_pick + CW'(1);
                        // A full wrap leaves every digit at zero, ready for the next length.
                        r_digit  <= w_digit_nxt;
                        if (w_wrap_all) begin
                            if (r_len < r_max_len) begin
                                r_len <= r_len + LW'(1);
                            end else begin
                                exhausted <= 1'b1;
                                r_state   <= S_DONE;
                            end
                        end
                    end
                    if (match_valid) begin
                        found      <= 1'b1;
                        found_core <= match_core;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (match_valid && !found) begin
                        found      <= 1'b1;
                        found_core <= match_core;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef KS_PROGRESS_EN
    logic [47:0] r_cand_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand_count <= '0;
        end else if (abort) begin
            r_cand_count <= '0;
        end else if ((r_state == S_IDLE) && !cfg_load && start && r_cfg_loaded && !cfg_err) begin
            r_cand_count <= '0;
        end else if (w_xfer && (r_cand_count != '1)) begin
            r_cand_count <= r_cand_count + 48'd1;
        end
    end

    assign cand_count = r_cand_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_keyspace_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_keyspace_sequencer
// Description : Directed and randomized bench for keyspace_sequencer using a
//               numeric (value-per-length) reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keyspace_sequencer;
    localparam int MAXLEN = 16;
    localparam int NCORES = 4;
    localparam int LW     = 5;
    localparam int CW     = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                cfg_load = 1'b0;
    logic [7:0]          cfg_numchars = '0;
    logic [LW-1:0]       cfg_min_len = '0;
    logic [LW-1:0]       cfg_max_len = '0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [NCORES-1:0]   core_ready = '0;
    logic                out_valid;
    logic [CW-1:0]       out_core;
    logic [8*MAXLEN-1:0] out_idx;
    logic [LW-1:0]       out_len;
    logic                match_valid = 1'b0;
    logic [CW-1:0]       match_core = '0;
    logic                busy;
    logic                exhausted;
    logic                found;
    logic [CW-1:0]       found_core;
    logic                cfg_err;
`ifdef KS_PROGRESS_EN
    logic [47:0]         cand_count;
`endif

    keyspace_sequencer #(.MAXLEN(MAXLEN), .NCORES(NCORES), .LW(LW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_numchars(cfg_numchars),
        .cfg_min_len(cfg_min_len), .cfg_max_len(cfg_max_len), .start(start), .abort(abort),
        .core_ready(core_ready), .out_valid(out_valid), .out_core(out_core), .out_idx(out_idx),
        .out_len(out_len), .match_valid(match_valid), .match_core(match_core), .busy(busy),
        .exhausted(exhausted), .found(found), .found_core(found_core),
`ifdef KS_PROGRESS_EN
        .cand_count(cand_count),
`endif
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: the current candidate is the m_val-th string of length m_len in base m_nc.
    int     m_nc, m_min, m_len, m_max, m_ptr;
    longint m_val, m_xfers;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint powi(input int b, input int e);
        longint r = 1;
        for (int i = 0; i < e; i++) r = r * b;
        return r;
    endfunction

    function automatic logic [8*MAXLEN-1:0] idx_of(input int nc, input int len, input longint v);
        logic [8*MAXLEN-1:0] r = '0;
        longint x = v;
        for (int i = 0; i < len; i++) begin
            r[8*i +: 8] = 8'(x % nc);
            x = x / nc;
        end
        return r;
    endfunction

    function automatic int pick(input logic [NCORES-1:0] rdy, input int ptr);
        for (int k = 0; k < NCORES; k++) begin
            if (rdy[(ptr + k) % NCORES]) return (ptr + k) % NCORES;
        end
        return -1;
    endfunction

    task automatic do_cfg(input int nc, input int mn, input int mx);
        cfg_numchars = 8'(nc);
        cfg_min_len  = LW'(mn);
        cfg_max_len  = LW'(mx);
        cfg_load     = 1'b1;
        tick();
        cfg_load     = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start   = 1'b0;
        m_len   = m_min;
        m_val   = 0;
        m_ptr   = 0;
        m_xfers = 0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic walk_cycle(input logic [NCORES-1:0] rdy, output bit fin);
        int p;
        fin = 1'b0;
        core_ready = rdy;
        @(negedge clk);
        p = pick(rdy, m_ptr);
        if (p < 0) begin
            chk("stall_valid", out_valid, 0);
        end else begin
            chk("valid", out_valid, 1);
            chk("core", out_core, p);
            chk("len", out_len, m_len);
            chk("idx", out_idx, idx_of(m_nc, m_len, m_val));
            m_ptr = (p + 1) % NCORES;
            m_val++;
            m_xfers++;
            if (m_val == powi(m_nc, m_len)) begin
                if (m_len == m_max) fin = 1'b1;
                else begin
                    m_len++;
                    m_val = 0;
                end
            end
        end
        tick();
    endtask

    task automatic run_full(input int nc, input int mn, input int mx, input bit rnd,
                            input logic [NCORES-1:0] fixed_rdy);
        bit fin = 1'b0;
        do_abort();
        m_nc = nc; m_min = mn; m_max = mx;
        do_cfg(nc, mn, mx);
        chk("cfg_ok", cfg_err, 0);
        do_start();
        chk("start_busy", busy, 1);
        for (int n = 0; n < 1000 && !fin; n++) begin
            walk_cycle(rnd ? NCORES'($urandom) : fixed_rdy, fin);
        end
        chk("walk_bound", fin, 1);
        core_ready = '1;
        @(negedge clk);
        chk("exh_flag", exhausted, 1);
        chk("exh_busy", busy, 0);
        chk("exh_valid", out_valid, 0);
`ifdef KS_PROGRESS_EN
        chk("cand_count", cand_count, m_xfers);
`endif
        tick();
    endtask

    initial begin
        bit fin;
        int nc, mn, mx;
        core_ready = '1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_exh", exhausted, 0);
        chk("rst_found", found, 0);
        chk("rst_fcore", found_core, 0);
        chk("rst_cfgerr", cfg_err, 0);
        rst_n = 1'b1;
        tick();

        // No config loaded yet: start must be ignored.
        start = 1'b1; tick(); start = 1'b0;
        chk("nocfg_busy", busy, 0);

        // Illegal configurations.
        do_cfg(0, 1, 2);   chk("err_nc0", cfg_err, 1);
        start = 1'b1; tick(); start = 1'b0;
        chk("err_busy", busy, 0);
        do_cfg(3, 3, 2);   chk("err_minmax", cfg_err, 1);
        do_cfg(3, 1, 17);  chk("err_maxlen", cfg_err, 1);
        do_cfg(200, 1, 2); chk("err_nc_big", cfg_err, 1);

        // Single-core style walk: 3 chars, lengths 1..2 -> 12 candidates.
        run_full(3, 1, 2, 1'b0, 4'b0001);

        // Randomized walks under random ready patterns.
        for (int r = 0; r < 4; r++) begin
            nc = $urandom_range(1, 5);
            mn = $urandom_range(1, 3);
            mx = $urandom_range(mn, 3);
            run_full(nc, mn, mx, 1'b1, 4'b0000);
        end

        // Unary charset: one all-zero candidate per length.
        run_full(1, 2, 4, 1'b0, 4'b1111);

        // cfg_load with start: config wins, start ignored.
        do_abort();
        m_nc = 5; m_min = 3; m_max = 3;
        cfg_numchars = 8'd5; cfg_min_len = 5'd3; cfg_max_len = 5'd3;
        cfg_load = 1'b1; start = 1'b1;
        tick();
        cfg_load = 1'b0; start = 1'b0;
        chk("cfgstart_busy", busy, 0);
        do_start();
        for (int i = 0; i < 4; i++) walk_cycle(4'b1010, fin);
        for (int i = 0; i < 5; i++) walk_cycle(4'b1111, fin);

        // Abort beats a coincident match.
        abort = 1'b1; match_valid = 1'b1; match_core = 2'd1;
        tick();
        abort = 1'b0; match_valid = 1'b0;
        core_ready = '1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_found", found, 0);
        tick();
        do_start();
        walk_cycle(4'b1111, fin);
        for (int i = 0; i < 3; i++) walk_cycle(4'b0110, fin);
        for (int i = 0; i < 10; i++) walk_cycle(4'b0000, fin);
        for (int i = 0; i < 3; i++) walk_cycle(4'b1001, fin);

        // Match on RUN cycle 5, then a late second match.
        do_abort();
        m_nc = 4; m_min = 2; m_max = 4;
        do_cfg(4, 2, 4);
        do_start();
        for (int i = 0; i < 4; i++) walk_cycle(4'b1111, fin);
        match_valid = 1'b1; match_core = 2'd2;
        walk_cycle(4'b1111, fin);
        match_valid = 1'b0;
        @(negedge clk);
        chk("match_found", found, 1);
        chk("match_core", found_core, 2);
        chk("match_valid_off", out_valid, 0);
        chk("match_busy", busy, 0);
        chk("match_exh", exhausted, 0);
        tick();
        match_valid = 1'b1; match_core = 2'd1;
        tick();
        match_valid = 1'b0;
        chk("match2_core", found_core, 2);

        // Reset mid-RUN: immediate IDLE, config lost.
        do_abort();
        do_start();
        walk_cycle(4'b1111, fin);
        walk_cycle(4'b1111, fin);
        core_ready = '1;
        rst_n = 1'b0;
        #1;
        chk("rstrun_valid", out_valid, 0);
        chk("rstrun_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        chk("rstrun_nostart", busy, 0);

        // Fresh config after reset walks from all-zero min length.
        m_nc = 2; m_min = 2; m_max = 2;
        do_cfg(2, 2, 2);
        do_start();
        for (int i = 0; i < 4; i++) walk_cycle(4'b1111, fin);
        chk("post_rst_fin", fin, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
